switch_debouncer: RTL and testbench



---
 rtl/switch_debouncer.sv | 111 +++++++++++
 tb/tb_switch_debouncer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus per-bit stability counter for slide switches.
// Ports: clk_clk, reset_reset_n (async low), sw_raw in; sw_stable/rise/fall, ready out.
module switch_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             ready
);

  typedef enum logic [1:0] {
    INIT0,
    INIT1,
    LOAD,
    RUN
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state;
  state_t state_nx;
  logic   load;
  logic   run;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] hit;
  logic [CNT_W-1:0] cnt [WIDTH];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= INIT0;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    run      = 1'b0;
    unique case (state)
      INIT0: state_nx = INIT1;
      INIT1: state_nx = LOAD;
      LOAD: begin
        state_nx = RUN;
        load     = 1'b1;
      end
      RUN: run = 1'b1;
      default: state_nx = INIT0;
    endcase
  end

  // A bit is accepted on the edge where its mismatch run reaches the window.
  always_comb begin
    diff = sync2 ^ sw_stable;
    hit  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hit[i] = diff[i] && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1     <= '0;
      sync2     <= '0;
      sw_stable <= '0;
      sw_rise   <= '0;
      sw_fall   <= '0;
      ready     <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= sw_raw;
      sync2   <= sync1;
      sw_rise <= '0;
      sw_fall <= '0;
      if (load) begin
        sw_stable <= sync2;
        ready     <= 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
          cnt[i] <= '0;
        end
      end else if (run) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (hit[i]) begin
            sw_stable[i] <= sync2[i];
            sw_rise[i]   <= sync2[i];
            sw_fall[i]   <= ~sync2[i];
            cnt[i]       <= '0;
          end else if (diff[i]) begin
            cnt[i] <= cnt[i] + CNT_ONE;
          end else begin
            cnt[i] <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer.
// Window-based reference model on a recorded raw-input history.
module tb_switch_debouncer;

  localparam int W  = 4;
  localparam int DC = 8;
  localparam int HN = 8192;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_stable;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         ready;

  int tests = 0;
  int fails = 0;

  int           n;
  logic [W-1:0] raw_h [HN];
  logic [W-1:0] m_stable;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;
  logic         m_ready;
  int           start [W];

  always #5 clk = ~clk;

  switch_debouncer #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .sw_raw(sw_raw),
    .sw_stable(sw_stable),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .ready(ready)
  );

  task automatic model_clear();
    n        = 0;
    m_stable = '0;
    m_rise   = '0;
    m_fall   = '0;
    m_ready  = 1'b0;
    for (int i = 0; i < W; i++) start[i] = 0;
  endtask

  // One clock: record the raw level seen at the edge, then apply the rule
  // "accept a bit once its synchronized value (raw two edges back) has
  // disagreed with the accepted level for DC edges since the last accept".
  task automatic tick();
    bit all;
    @(posedge clk);
    n++;
    if (n >= HN) begin
      $display("FAIL history_overflow got %0d limit %0d", n, HN);
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1);
    end
    raw_h[n] = sw_raw;
    m_rise   = '0;
    m_fall   = '0;
    if (n == 3) begin
      m_stable = raw_h[1];
      m_ready  = 1'b1;
      for (int i = 0; i < W; i++) start[i] = 3;
    end else if (n > 3) begin
      for (int i = 0; i < W; i++) begin
        if (n - DC + 1 > start[i]) begin
          all = 1'b1;
          for (int k = n - DC + 1; k <= n; k++) begin
            if (raw_h[k-2][i] == m_stable[i]) all = 1'b0;
          end
          if (all) begin
            m_rise[i]   = ~m_stable[i];
            m_fall[i]   = m_stable[i];
            m_stable[i] = ~m_stable[i];
            start[i]    = n;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    sw_raw = 4'b1010;
    rst_n  = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    tests++;
    if ({sw_stable, sw_rise, sw_fall, ready} !== '0) begin
      fails++;
      $display("FAIL reset_hold got %b/%b/%b/%b want 0",
               sw_stable, sw_rise, sw_fall, ready);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      tests++;
      if ({sw_stable, sw_rise, sw_fall, ready} !==
          {m_stable, m_rise, m_fall, m_ready}) begin
        fails++;
        $display("FAIL reset_model c%0d got %b/%b/%b/%b want %b/%b/%b/%b",
                 c, sw_stable, sw_rise, sw_fall, ready,
                 m_stable, m_rise, m_fall, m_ready);
      end
      tests++;
      if (ready !== (c >= 3) || (sw_rise | sw_fall) !== '0 ||
          (c >= 3 && sw_stable !== 4'b1010)) begin
        fails++;
        $display("FAIL power_up c%0d got rdy=%b st=%b r=%b f=%b want rdy=%b st=1010",
                 c, ready, sw_stable, sw_rise, sw_fall, c >= 3);
      end
    end
  endtask

  task automatic test_clean_edge();
    logic [W-1:0] er;
    sw_raw[0] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      er = (c == 10) ? 4'b0001 : 4'b0000;
      tests++;
      if ({sw_stable, sw_rise, sw_fall, ready} !==
          {m_stable, m_rise, m_fall, m_ready}) begin
        fails++;
        $display("FAIL clean_model c%0d got %b/%b/%b want %b/%b/%b",
                 c, sw_stable, sw_rise, sw_fall, m_stable, m_rise, m_fall);
      end
      tests++;
      if (sw_rise !== er || sw_stable[0] !== (c >= 10)) begin
        fails++;
        $display("FAIL clean_edge c%0d got r=%b st0=%b want r=%b st0=%b",
                 c, sw_rise, sw_stable[0], er, c >= 10);
      end
    end
  endtask

  task automatic test_bounce();
    sw_raw[1] = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      tests++;
      if ({sw_stable, sw_rise, sw_fall} !== {m_stable, m_rise, m_fall}) begin
        fails++;
        $display("FAIL bounce_prep c%0d got %b/%b/%b want %b/%b/%b",
                 c, sw_stable, sw_rise, sw_fall, m_stable, m_rise, m_fall);
      end
    end
    for (int c = 0; c < 60; c++) begin
      sw_raw[1] = (c % 6) != 5;
      tick();
      tests++;
      if (sw_stable[1] !== 1'b0 || sw_rise[1] !== 1'b0 ||
          sw_fall[1] !== 1'b0 ||
          {sw_stable, sw_rise, sw_fall} !== {m_stable, m_rise, m_fall}) begin
        fails++;
        $display("FAIL bounce c%0d got st=%b r=%b f=%b want st=%b r=%b f=%b",
                 c, sw_stable, sw_rise, sw_fall, m_stable, m_rise, m_fall);
      end
    end
    sw_raw[1] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      tests++;
      if (sw_rise[1] !== (c == 10) || sw_stable[1] !== (c >= 10) ||
          {sw_stable, sw_rise, sw_fall} !== {m_stable, m_rise, m_fall}) begin
        fails++;
        $display("FAIL bounce_hold c%0d got st=%b r=%b want st1=%b r1=%b",
                 c, sw_stable, sw_rise, c >= 10, c == 10);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] er;
    logic [W-1:0] ef;
    sw_raw = 4'b0011;
    repeat (12) begin
      tick();
      tests++;
      if ({sw_stable, sw_rise, sw_fall} !== {m_stable, m_rise, m_fall}) begin
        fails++;
        $display("FAIL simul_prep got %b/%b/%b want %b/%b/%b",
                 sw_stable, sw_rise, sw_fall, m_stable, m_rise, m_fall);
      end
    end
    sw_raw = 4'b1010;
    for (int c = 1; c <= 12; c++) begin
      tick();
      er = (c == 10) ? 4'b1000 : 4'b0000;
      ef = (c == 10) ? 4'b0001 : 4'b0000;
      tests++;
      if (sw_rise !== er || sw_fall !== ef || sw_stable[2:1] !== 2'b01 ||
          sw_stable !== m_stable) begin
        fails++;
        $display("FAIL simultaneous c%0d got st=%b r=%b f=%b want st=%b r=%b f=%b",
                 c, sw_stable, sw_rise, sw_fall, m_stable, er, ef);
      end
    end
  endtask

  task automatic test_reset_mid();
    sw_raw = 4'b1110;
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({sw_stable, sw_rise, sw_fall, ready} !== '0) begin
      fails++;
      $display("FAIL async_reset got %b/%b/%b/%b want 0",
               sw_stable, sw_rise, sw_fall, ready);
    end
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      tests++;
      if ({sw_stable, sw_rise, sw_fall, ready} !==
          {m_stable, m_rise, m_fall, m_ready} ||
          (sw_rise | sw_fall) !== '0 ||
          (c >= 3 && sw_stable !== 4'b1110)) begin
        fails++;
        $display("FAIL reload c%0d got %b/%b/%b/%b want %b/0000/0000/%b",
                 c, sw_stable, sw_rise, sw_fall, ready, m_stable, m_ready);
      end
    end
  endtask

  task automatic test_long_hold();
    int strobes;
    strobes   = 0;
    sw_raw[2] = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      strobes += int'(sw_rise[2]) + int'(sw_fall[2]);
      tests++;
      if ({sw_stable, sw_rise, sw_fall} !== {m_stable, m_rise, m_fall}) begin
        fails++;
        $display("FAIL long_model c%0d got %b/%b/%b want %b/%b/%b",
                 c, sw_stable, sw_rise, sw_fall, m_stable, m_rise, m_fall);
      end
    end
    tests++;
    if (strobes != 1 || sw_stable[2] !== 1'b0) begin
      fails++;
      $display("FAIL long_hold got strobes=%0d st2=%b want 1 and 0",
               strobes, sw_stable[2]);
    end
  endtask

  task automatic test_random();
    int rate;
    for (int ph = 0; ph < 2; ph++) begin
      rate = (ph == 0) ? 3 : 20;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(rate - 1, 0) == 0) begin
          sw_raw[$urandom_range(W - 1, 0)] ^= 1'b1;
        end
        tick();
        tests++;
        if ({sw_stable, sw_rise, sw_fall, ready} !==
            {m_stable, m_rise, m_fall, m_ready} ||
            (sw_rise & sw_fall) !== '0) begin
          fails++;
          $display("FAIL random p%0d c%0d got %b/%b/%b want %b/%b/%b",
                   ph, c, sw_stable, sw_rise, sw_fall,
                   m_stable, m_rise, m_fall);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_edge();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_long_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
